// File: rtl/pipelined_addsub.sv
// pipelined_addsub: pipelined two's-complement adder/subtractor with handshake and flags.
//
// The operands are split into STAGES chunks of CW = WIDTH/STAGES bits. WIDTH must be a
// multiple of STAGES. The accept edge loads an operand register that holds a, the
// conditionally inverted b and the initial carry. Stage k then adds chunk k and
// registers the carry for stage k+1. A result therefore shows up STAGES edges after its
// accept edge. The pipe holds STAGES+1 slots, and all of them stall together.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; empties the pipe and clears the outputs
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle (= advance)
//   a, b       operands, WIDTH bits
//   cin        carry in, used by ADC/SBC only
//   op         00 ADD, 01 SUB, 10 ADC, 11 SBC
//   out_valid  result beat valid
//   out_ready  consumer accepts the result
//   s          result, modulo 2^WIDTH
//   cout       carry out of MSB (SUB/SBC: 1 = no borrow)
//   overflow   signed overflow
//   zero       s == 0
//   negative   s[WIDTH-1]
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned CW = WIDTH / STAGES;

  // Slot 0 is the operand register. Slot k+1 is the output of stage k.
  // w: remaining a chunks in the low part, finished sum chunks shifted in from the top.
  //    After STAGES stages it holds the full result in natural order.
  // b: rotated right by one chunk per stage, so the current chunk is always at the bottom.
  logic [STAGES:0][WIDTH-1:0] w_q, w_d;
  logic [STAGES:0][WIDTH-1:0] b_q, b_d;
  logic [STAGES:0]            c_q, c_d;
  logic [STAGES:0]            v_q, v_d;
  logic                       ovf_q, ovf_d;
  logic                       zero_q, zero_d;

  logic                       advance;
  logic [CW:0]                chunk;
  logic                       cmsb;

  assign advance  = ~v_q[STAGES] | out_ready;
  assign in_ready = advance;

  always_comb begin
    w_d    = w_q;
    b_d    = b_q;
    c_d    = c_q;
    v_d    = v_q;
    chunk  = '0;
    cmsb   = 1'b0;
    ovf_d  = ovf_q;
    zero_d = zero_q;

    // Operand prep. The initial carry is 0 for ADD, 1 for SUB, and cin for ADC/SBC.
    w_d[0] = a;
    b_d[0] = op[0] ? ~b : b;
    c_d[0] = op[1] ? cin : op[0];
    v_d[0] = in_valid;

    for (int k = 0; k < int'(STAGES); k++) begin
      chunk    = {1'b0, w_q[k][CW-1:0]} + {1'b0, b_q[k][CW-1:0]} + {{CW{1'b0}}, c_q[k]};
      w_d[k+1] = (w_q[k] >> CW) | (WIDTH'(chunk[CW-1:0]) << (WIDTH - CW));
      b_d[k+1] = (b_q[k] >> CW) | (b_q[k] << (WIDTH - CW));
      c_d[k+1] = chunk[CW];
      v_d[k+1] = v_q[k];
    end

    // chunk now holds the last stage's sum. Recover the carry into the MSB from the sum bit.
    cmsb   = w_q[STAGES-1][CW-1] ^ b_q[STAGES-1][CW-1] ^ chunk[CW-1];
    ovf_d  = cmsb ^ chunk[CW];
    zero_d = (w_d[STAGES] == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      v_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      w_q    <= w_d;
      b_q    <= b_d;
      c_q    <= c_d;
      v_q    <= v_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = v_q[STAGES];
  assign s         = w_q[STAGES];
  assign cout      = c_q[STAGES];
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign negative  = w_q[STAGES][WIDTH-1];

  // The rotated b copy after the last stage has no consumer.
  logic unused_b_tail;
  assign unused_b_tail = ^b_q[STAGES];

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed bench for pipelined_addsub.
// It runs two instances: WIDTH=16/STAGES=4 (dut) and WIDTH=32/STAGES=1 (dut2).
module tb_pipelined_addsub;

  logic        clk;
  logic        reset;

  logic        in_valid, in_ready, cin, out_valid, out_ready;
  logic [1:0]  op;
  logic [15:0] a, b, s;
  logic        cout, ovf, zero, neg;

  logic        in_valid2, in_ready2, cin2, out_valid2, out_ready2;
  logic [1:0]  op2;
  logic [31:0] a2, b2, s2;
  logic        cout2, ovf2, zero2, neg2;

  int n_asserts = 0;
  int n_fail    = 0;

  pipelined_addsub #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .op(op), .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout),
    .overflow(ovf), .zero(zero), .negative(neg)
  );

  pipelined_addsub #(.WIDTH(32), .STAGES(1)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
    .cin(cin2), .op(op2), .out_valid(out_valid2), .out_ready(out_ready2), .s(s2),
    .cout(cout2), .overflow(ovf2), .zero(zero2), .negative(neg2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one beat on dut, then wait for its result.
  // Checks the latency, the result and all flags.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] xa,
                        input logic [15:0] xb, input logic xc, input logic [15:0] es,
                        input logic ec, input logic ev, input logic ez, input logic en);
    int lat;
    op = o; a = xa; b = xb; cin = xc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_s"}, s, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, ev);
    check({tag, "_zero"}, zero, ez);
    check({tag, "_neg"}, neg, en);
    tick();
  endtask

  task automatic run_op2(input string tag, input logic [1:0] o, input logic [31:0] xa,
                         input logic [31:0] xb, input logic xc, input logic [31:0] es,
                         input logic ec, input logic ev, input logic ez, input logic en);
    int lat;
    op2 = o; a2 = xa; b2 = xb; cin2 = xc; in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 1);
    check({tag, "_s"}, s2, es);
    check({tag, "_cout"}, cout2, ec);
    check({tag, "_ovf"}, ovf2, ev);
    check({tag, "_zero"}, zero2, ez);
    check({tag, "_neg"}, neg2, en);
    tick();
  endtask

  initial begin
    logic [15:0] q[$];
    logic [15:0] held_s;
    logic        held_valid;
    int          sent, rx, first, last, seen;

    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; op = 2'b00;
    in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0; cin2 = 1'b0; op2 = 2'b00;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_s", s, 0);
    check("rst_flags", {cout, ovf, zero, neg}, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst2_out_valid", out_valid2, 0);
    check("rst2_in_ready", in_ready2, 1);

    // Directed arithmetic, one beat at a time
    run_op("add_ovf", 2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op("sub_eq", 2'b01, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("sub_borrow", 2'b01, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("adc_wrap", 2'b10, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("sbc_ovf", 2'b11, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("adc_c0", 2'b10, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sbc_c0", 2'b11, 16'h0003, 16'h0001, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("add_ign_cin", 2'b00, 16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sub_ign_cin", 2'b01, 16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("add_chunk", 2'b00, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stream of 8 ADD beats with in_valid held: results must come out on consecutive cycles.
    rx = 0; first = -1; last = -1;
    for (int c = 0; c < 16; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; op = 2'b00; cin = 1'b0;
        a = 16'(c); b = 16'(c * 16'h0101);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (out_valid) begin
        check("stream_s", s, 32'(rx * 16'h0102));
        rx++;
        if (first < 0) first = c;
        last = c;
      end
    end
    check("stream_count", rx, 8);
    check("stream_span", last - first, 7);

    // Stream with out_ready low for 5 cycles: no loss or duplication, and outputs frozen.
    q.delete(); sent = 0; rx = 0; held_valid = 1'b0; held_s = '0;
    for (int c = 0; c < 60 && rx < 8; c++) begin
      out_ready = !(c >= 6 && c < 11);
      in_valid  = (sent < 8);
      op = 2'b00; cin = 1'b0;
      a = 16'(sent * 17); b = 16'h0F00;
      #1;
      if (in_valid && in_ready) begin
        q.push_back(a + b);
        sent++;
      end
      if (out_valid) begin
        if (out_ready) begin
          check("stall_s", s, q.pop_front());
          rx++;
        end else begin
          check("stall_in_ready", in_ready, 0);
          if (held_valid) check("stall_hold_s", s, held_s);
          held_s = s;
          held_valid = 1'b1;
        end
      end
      if (out_ready) held_valid = 1'b0;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stall_rx", rx, 8);
    check("stall_sent", sent, 8);
    check("stall_queue_empty", q.size(), 0);
    tick();
    check("stall_drained", out_valid, 0);

    // Reset with 3 beats in flight
    for (int i = 0; i < 3; i++) begin
      op = 2'b00; a = 16'(16'h0100 * (i + 1)); b = 16'h0001; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("flush_out_valid", out_valid, 0);
    reset = 1'b0;
    check("flush_in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("flush_no_ghost", seen, 0);
    run_op("after_flush", 2'b00, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while a result is held by backpressure
    out_ready = 1'b0;
    op = 2'b00; a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    check("held_valid", out_valid, 1);
    reset = 1'b1;
    tick();
    check("held_reset_drop", out_valid, 0);
    reset = 1'b0;
    out_ready = 1'b1;

    // WIDTH=32, STAGES=1: fill against backpressure, reset, then normal beats.
    out_ready2 = 1'b0;
    op2 = 2'b00; a2 = 32'h1; b2 = 32'h1; in_valid2 = 1'b1;
    repeat (3) tick();
    in_valid2 = 1'b0;
    check("w32_full_valid", out_valid2, 1);
    check("w32_full_in_ready", in_ready2, 0);
    reset = 1'b1;
    tick();
    check("w32_flush_valid", out_valid2, 0);
    reset = 1'b0;
    out_ready2 = 1'b1;
    tick();
    check("w32_no_ghost", out_valid2, 0);
    run_op2("w32_add_wrap", 2'b00, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op2("w32_sub_ovf", 2'b01, 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF,
            1'b1, 1'b1, 1'b0, 1'b0);
    run_op2("w32_adc_ovf", 2'b10, 32'h7FFF_FFFF, 32'h0, 1'b1, 32'h8000_0000,
            1'b0, 1'b1, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
